// File: rtl/dlfloat16_i2f.sv
// Integer to DLFloat16 converter (1/6/9, bias 31, RNE), one operand in flight.
// Define DLF_I2F_FAST_NORM_EN for a single-cycle leading-zero normalize instead of the 1-bit/cycle shifter.
module dlfloat16_i2f #(
    parameter int IW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_data,
    input  logic          in_signed,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_data,
    output logic [4:0]    exceptions
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

    // Bits below the guard position feed the sticky bit; empty when IW == 11.
    localparam logic [IW-1:0] ST_MASK = IW'((64'd1 << (IW - 11)) - 64'd1);

    state_t        state, state_nxt;
    logic          s_q, s_nxt;
    logic [IW-1:0] mag_q, mag_nxt;
    logic [4:0]    e_q, e_nxt;
    logic [15:0]   data_q, data_nxt;
    logic [4:0]    exc_q, exc_nxt;

    logic [8:0]    mant;
    logic          g, st, rnd_up;
    logic [9:0]    mant_sum;
    logic [5:0]    e_fin, exp_field;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == OUT);
    assign out_data   = data_q;
    assign exceptions = exc_q;

    assign mant      = mag_q[IW-2:IW-10];
    assign g         = mag_q[IW-11];
    assign st        = |(mag_q & ST_MASK);
    assign rnd_up    = g & (st | mant[0]);
    assign mant_sum  = {1'b0, mant} + 10'(rnd_up);
    // Mantissa overflow leaves all-zero fraction bits and bumps the exponent.
    assign e_fin     = {1'b0, e_q} + 6'(mant_sum[9]);
    assign exp_field = e_fin + 6'd31;

`ifdef DLF_I2F_FAST_NORM_EN
    logic [4:0] lz;
    always_comb begin
        lz = '0;
        for (int i = 0; i < IW; i++)
            if (mag_q[i]) lz = 5'(IW - 1 - i);
    end
`endif

    always_comb begin
        state_nxt = state;
        s_nxt     = s_q;
        mag_nxt   = mag_q;
        e_nxt     = e_q;
        data_nxt  = data_q;
        exc_nxt   = exc_q;
        case (state)
            IDLE: if (in_valid) begin
                s_nxt     = in_signed & in_data[IW-1];
                mag_nxt   = s_nxt ? (~in_data + IW'(1)) : in_data;
                e_nxt     = 5'(IW - 1);
                state_nxt = NORM;
            end
            NORM: begin
                if (mag_q == '0) begin
                    data_nxt  = 16'h0000;
                    exc_nxt   = 5'b00001;
                    state_nxt = OUT;
                end else begin
`ifdef DLF_I2F_FAST_NORM_EN
                    mag_nxt   = mag_q << lz;
                    e_nxt     = e_q - lz;
                    state_nxt = ROUND;
`else
                    if (mag_q[IW-1]) begin
                        state_nxt = ROUND;
                    end else begin
                        mag_nxt = mag_q << 1;
                        e_nxt   = e_q - 5'd1;
                    end
`endif
                end
            end
            ROUND: begin
                data_nxt  = {s_q, exp_field, mant_sum[8:0]};
                exc_nxt   = {1'b0, g | st, 3'b000};
                state_nxt = OUT;
            end
            OUT: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            s_q    <= 1'b0;
            mag_q  <= '0;
            e_q    <= '0;
            data_q <= 16'h0000;
            exc_q  <= 5'b00000;
        end else begin
            state  <= state_nxt;
            s_q    <= s_nxt;
            mag_q  <= mag_nxt;
            e_q    <= e_nxt;
            data_q <= data_nxt;
            exc_q  <= exc_nxt;
        end
    end
endmodule
